control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 IR  in  32  instruction register contents. Opcode is IR[31:27].
REQ-005 con_ff  in  1  branch-condition flip-flop output from the datapath.
REQ-006 stop  in  1  external halt request.
REQ-007 PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout  out  1 each  bus-source selects.
REQ-008 MARin, MDRin, IRin, Yin, PCin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin  out  1 each  register load enables.
REQ-009 IncPC, Read, Write  out  1 each  PC increment, MDR-from-memory select, RAM write enable.
REQ-010 GRA, GRB, GRC, R_in, R_out, Baout  out  1 each  IR register-field select/enable strobes.
REQ-011 alu_op  out  5  ALU operation code.
REQ-012 run  out  1  high while executing; low in RST and HALT.

Function
REQ-013 The state register SHALL hold one of: RST, T0–T7, HALT. Every output not listed as asserted for a state SHALL be 0 in that state.
REQ-014 Outputs SHALL be decoded from state and IR[31:27] only. Sole exception: PCin in the branch T6 step, which equals con_ff.
REQ-015 Fetch sequence:
- T0: PCout, MARin, IncPC.
- T1: Read, MDRin.
- T2: MDRout, IRin.
- T3 onward: the execute sequence selected by IR[31:27].
REQ-016 ALU register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
- T3: GRB, R_out, Yin.
- T4: GRC, R_out, ZHighIn, ZLowIn.
- T5: ZLowout, GRA, R_in.
REQ-017 neg 10001 and not 10010 SHALL follow REQ-016, except T4 uses GRB instead of GRC.
REQ-018 mul 01111 and div 10000:
- T3: GRB, R_out, Yin.
- T4: GRC, R_out, ZHighIn, ZLowIn.
- T5: ZLowout, LOin.
- T6: ZHighout, HIin.
REQ-019 addi 01100, andi 01101, ori 01110:
- T3: GRB, R_out, Yin.
- T4: Cout, ZHighIn, ZLowIn.
- T5: ZLowout, GRA, R_in.
REQ-020 ldi 00001 SHALL follow REQ-019, except T3 uses Baout instead of R_out.
REQ-021 ld 00000:
- T3: GRB, Baout, Yin.
- T4: Cout, ZHighIn, ZLowIn.
- T5: ZLowout, MARin.
- T6: Read, MDRin.
- T7: MDRout, GRA, R_in.
REQ-022 st 00010:
- T3–T5: as ld.
- T6: GRA, R_out, MDRin (Read=0).
- T7: Write.
REQ-023 br 10011:
- T3: GRA, R_out, CONin.
- T4: PCout, Yin.
- T5: Cout, ZHighIn, ZLowIn.
- T6: ZLowout; PCin=con_ff.
REQ-024 Single-step ops, all at T3:
- jr 10100: GRA, R_out, PCin.
- in 10110: InPortout, GRA, R_in.
- out 10111: GRA, R_out, OutPortin.
- mfhi 11000: HIout, GRA, R_in.
- mflo 11001: LOout, GRA, R_in.
REQ-025 nop 11010, and any opcode not listed above, SHALL pass through T3 with no strobes.
REQ-026 After the last step of any sequence, the next state SHALL be T0. Instruction latency therefore = 3 fetch cycles + execute length (1–5 cycles).
REQ-027 halt 11011: state SHALL go from T3 to HALT.
REQ-028 stop=1 sampled in T0 SHALL send the state to HALT on that edge, instead of T1, and the T0 strobes SHALL NOT repeat.
REQ-029 HALT SHALL persist until clr; all strobes are 0 and run=0.
REQ-030 alu_op SHALL equal IR[31:27] during T4 of ALU/immediate/neg/not/mul/div ops. In all other states alu_op SHALL be 00011 (add).
REQ-031 con_ff SHALL be ignored in every state except br T6.

Reset
REQ-032 clr=1 at a rising edge SHALL force RST from any state, including mid-instruction. In RST all outputs SHALL be 0 and run=0.
REQ-033 The first rising edge with clr=0 SHALL move RST to T0.
REQ-034 No partially executed instruction SHALL resume after reset.

Verification
REQ-035 Reset then release -> cycle after release: T0 with PCout=MARin=IncPC=1, run=1. During clr all outputs are 0.
REQ-036 IR=0x18918000 (add R1,R2,R3) -> T4 alu_op=00011 with GRC, R_out, ZLowIn; T5 ZLowout, GRA, R_in; next cycle T0. 6 cycles total.
REQ-037 IR=0x00900055 (ld R1,0x55(R2)) -> T3 Baout, T6 Read and MDRin, T7 MDRout and R_in. Write=0 throughout. 8 cycles total.
REQ-038 IR=0x99000010 (br) with con_ff=1 -> T6 PCin=1. Repeat with con_ff=0 -> T6 PCin=0; next state T0 in both cases.
REQ-039 IR=0xD8000000 (halt) -> HALT after T3, run=0 and no strobes for 10+ cycles. clr=1 -> RST, then T0.
REQ-040 clr asserted in st T6 -> RST on next edge, Write never asserted. Also: stop=1 in T0 -> HALT with T1 strobes never seen.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Hardwired fetch/execute sequencer for the 32-bit datapath.
// Decodes state and IR opcode into bus-source selects, register loads and ALU op.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        PCin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        CONin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        R_in,
  output logic        R_out,
  output logic        Baout,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, next_state;
  logic [4:0] op;
  logic       is_alu, is_unary, is_muldiv, is_imm, is_ldi, is_ld, is_st, is_br, is_halt;
  logic       unused_ir_bits;

  assign op             = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  assign is_alu    = (op >= OP_ADD) && (op <= OP_SHL);
  assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_ldi    = (op == OP_LDI);
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_br     = (op == OP_BR);
  assign is_halt   = (op == OP_HALT);

  always_ff @(posedge clk) begin
    if (clr) state <= S_RST;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_RST;
    case (state)
      S_RST:  next_state = S_T0;
      S_T0:   next_state = stop ? S_HALT : S_T1;
      S_T1:   next_state = S_T2;
      S_T2:   next_state = S_T3;
      S_T3: begin
        if (is_halt)
          next_state = S_HALT;
        else if (is_alu || is_unary || is_muldiv || is_imm || is_ldi ||
                 is_ld || is_st || is_br)
          next_state = S_T4;
        else
          next_state = S_T0;
      end
      S_T4:   next_state = S_T5;
      S_T5:   next_state = (is_muldiv || is_br || is_ld || is_st) ? S_T6 : S_T0;
      S_T6:   next_state = (is_ld || is_st) ? S_T7 : S_T0;
      S_T7:   next_state = S_T0;
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; PCin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0; CONin = 1'b0;
    OutPortin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; R_in = 1'b0; R_out = 1'b0; Baout = 1'b0;
    alu_op = OP_ADD;
    run    = 1'b1;
    case (state)
      S_RST: begin
        alu_op = 5'b00000;
        run    = 1'b0;
      end
      S_HALT: run = 1'b0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_unary || is_muldiv || is_imm) begin
          GRB = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          GRB = 1'b1; Baout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          GRA = 1'b1; R_out = 1'b1; CONin = 1'b1;
        end else if (op == OP_JR) begin
          GRA = 1'b1; R_out = 1'b1; PCin = 1'b1;
        end else if (op == OP_IN) begin
          InPortout = 1'b1; GRA = 1'b1; R_in = 1'b1;
        end else if (op == OP_OUT) begin
          GRA = 1'b1; R_out = 1'b1; OutPortin = 1'b1;
        end else if (op == OP_MFHI) begin
          HIout = 1'b1; GRA = 1'b1; R_in = 1'b1;
        end else if (op == OP_MFLO) begin
          LOout = 1'b1; GRA = 1'b1; R_in = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu || is_muldiv || is_unary) begin
          GRC = ~is_unary; GRB = is_unary; R_out = 1'b1;
          ZHighIn = 1'b1; ZLowIn = 1'b1; alu_op = op;
        end else if (is_imm) begin
          Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; alu_op = op;
        end else if (is_ldi || is_ld || is_st) begin
          Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_unary || is_imm || is_ldi) begin
          ZLowout = 1'b1; GRA = 1'b1; R_in = 1'b1;
        end else if (is_muldiv) begin
          ZLowout = 1'b1; LOin = 1'b1;
        end else if (is_ld || is_st) begin
          ZLowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          ZHighout = 1'b1; HIin = 1'b1;
        end else if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          GRA = 1'b1; R_out = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          // The only condition-dependent strobe: branch taken loads PC from Z.
          ZLowout = 1'b1; PCin = con_ff;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; R_in = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - Scoreboard bench for control_unit.
// Stimulus pushes the expected full output vector per cycle; a monitor compares at negedge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout;
  logic MARin, MDRin, IRin, Yin, PCin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin;
  logic IncPC, Read, Write, GRA, GRB, GRC, R_in, R_out, Baout, run;
  logic [4:0] alu_op;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .PCin(PCin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .CONin(CONin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .R_in(R_in), .R_out(R_out), .Baout(Baout),
    .alu_op(alu_op), .run(run)
  );

  always #5 clk = ~clk;

  logic [33:0] act;
  assign act = {alu_op, run, Baout, R_out, R_in, GRC, GRB, GRA, Write, Read, IncPC,
                OutPortin, CONin, ZLowIn, ZHighIn, LOin, HIin, PCin, Yin, IRin, MDRin,
                MARin, Cout, InPortout, LOout, HIout, MDRout, ZLowout, ZHighout, PCout};

  localparam logic [33:0] M_PCOUT  = 34'd1 << 0;
  localparam logic [33:0] M_ZHOUT  = 34'd1 << 1;
  localparam logic [33:0] M_ZLOUT  = 34'd1 << 2;
  localparam logic [33:0] M_MDROUT = 34'd1 << 3;
  localparam logic [33:0] M_HIOUT  = 34'd1 << 4;
  localparam logic [33:0] M_COUT   = 34'd1 << 7;
  localparam logic [33:0] M_MARIN  = 34'd1 << 8;
  localparam logic [33:0] M_MDRIN  = 34'd1 << 9;
  localparam logic [33:0] M_IRIN   = 34'd1 << 10;
  localparam logic [33:0] M_YIN    = 34'd1 << 11;
  localparam logic [33:0] M_PCIN   = 34'd1 << 12;
  localparam logic [33:0] M_HIIN   = 34'd1 << 13;
  localparam logic [33:0] M_LOIN   = 34'd1 << 14;
  localparam logic [33:0] M_ZHIN   = 34'd1 << 15;
  localparam logic [33:0] M_ZLIN   = 34'd1 << 16;
  localparam logic [33:0] M_CONIN  = 34'd1 << 17;
  localparam logic [33:0] M_INCPC  = 34'd1 << 19;
  localparam logic [33:0] M_READ   = 34'd1 << 20;
  localparam logic [33:0] M_WRITE  = 34'd1 << 21;
  localparam logic [33:0] M_GRA    = 34'd1 << 22;
  localparam logic [33:0] M_GRB    = 34'd1 << 23;
  localparam logic [33:0] M_GRC    = 34'd1 << 24;
  localparam logic [33:0] M_RIN    = 34'd1 << 25;
  localparam logic [33:0] M_ROUT   = 34'd1 << 26;
  localparam logic [33:0] M_BAOUT  = 34'd1 << 27;
  localparam logic [33:0] M_RUN    = 34'd1 << 28;

  function automatic logic [33:0] alu(input logic [4:0] o);
    return {o, 29'd0};
  endfunction

  // Running state with default add ALU code; HALT has add but run low; RST is all zero.
  localparam logic [33:0] RB   = M_RUN | (34'd3 << 29);
  localparam logic [33:0] HLT  = 34'd3 << 29;
  localparam logic [33:0] RSTV = 34'd0;

  typedef struct {
    logic [33:0] exp;
    string       tag;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    item_t it;
    if (q.size() > 0) begin
      it = q.pop_front();
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", it.tag, act, it.exp);
      end
    end
  end

  task automatic cyc(input logic [33:0] e, input string tag);
    item_t it;
    it.exp = e;
    it.tag = tag;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir, input string nm);
    IR = ir;
    cyc(RB | M_PCOUT | M_MARIN | M_INCPC, {nm, "_T0"});
    cyc(RB | M_READ | M_MDRIN, {nm, "_T1"});
    cyc(RB | M_MDROUT | M_IRIN, {nm, "_T2"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cyc(RSTV, "reset_hold0");
    cyc(RSTV, "reset_hold1");
    clr = 1'b0;
    cyc(RSTV, "reset_release");

    // add R1,R2,R3
    fetch(32'h18918000, "add");
    cyc(RB | M_GRB | M_ROUT | M_YIN, "add_T3");
    cyc(M_RUN | alu(5'b00011) | M_GRC | M_ROUT | M_ZHIN | M_ZLIN, "add_T4");
    cyc(RB | M_ZLOUT | M_GRA | M_RIN, "add_T5");

    // ld R1,0x55(R2)
    fetch(32'h00900055, "ld");
    cyc(RB | M_GRB | M_BAOUT | M_YIN, "ld_T3");
    cyc(RB | M_COUT | M_ZHIN | M_ZLIN, "ld_T4");
    cyc(RB | M_ZLOUT | M_MARIN, "ld_T5");
    cyc(RB | M_READ | M_MDRIN, "ld_T6");
    cyc(RB | M_MDROUT | M_GRA | M_RIN, "ld_T7");

    // br taken
    con_ff = 1'b1;
    fetch(32'h99000010, "br1");
    cyc(RB | M_GRA | M_ROUT | M_CONIN, "br1_T3");
    cyc(RB | M_PCOUT | M_YIN, "br1_T4");
    cyc(RB | M_COUT | M_ZHIN | M_ZLIN, "br1_T5");
    cyc(RB | M_ZLOUT | M_PCIN, "br1_T6");

    // br not taken; con_ff high elsewhere must not matter
    fetch(32'h99000010, "br0");
    cyc(RB | M_GRA | M_ROUT | M_CONIN, "br0_T3");
    cyc(RB | M_PCOUT | M_YIN, "br0_T4");
    cyc(RB | M_COUT | M_ZHIN | M_ZLIN, "br0_T5");
    con_ff = 1'b0;
    cyc(RB | M_ZLOUT, "br0_T6");
    con_ff = 1'b1;

    // neg uses GRB at T4
    fetch(32'h88000000, "neg");
    cyc(RB | M_GRB | M_ROUT | M_YIN, "neg_T3");
    cyc(M_RUN | alu(5'b10001) | M_GRB | M_ROUT | M_ZHIN | M_ZLIN, "neg_T4");
    cyc(RB | M_ZLOUT | M_GRA | M_RIN, "neg_T5");

    // mul
    fetch(32'h78000000, "mul");
    cyc(RB | M_GRB | M_ROUT | M_YIN, "mul_T3");
    cyc(M_RUN | alu(5'b01111) | M_GRC | M_ROUT | M_ZHIN | M_ZLIN, "mul_T4");
    cyc(RB | M_ZLOUT | M_LOIN, "mul_T5");
    cyc(RB | M_ZHOUT | M_HIIN, "mul_T6");

    // addi
    fetch(32'h60000000, "addi");
    cyc(RB | M_GRB | M_ROUT | M_YIN, "addi_T3");
    cyc(M_RUN | alu(5'b01100) | M_COUT | M_ZHIN | M_ZLIN, "addi_T4");
    cyc(RB | M_ZLOUT | M_GRA | M_RIN, "addi_T5");

    // st
    fetch(32'h10000000, "st");
    cyc(RB | M_GRB | M_BAOUT | M_YIN, "st_T3");
    cyc(RB | M_COUT | M_ZHIN | M_ZLIN, "st_T4");
    cyc(RB | M_ZLOUT | M_MARIN, "st_T5");
    cyc(RB | M_GRA | M_ROUT | M_MDRIN, "st_T6");
    cyc(RB | M_WRITE, "st_T7");

    // single-step and no-op opcodes
    fetch(32'hA0000000, "jr");
    cyc(RB | M_GRA | M_ROUT | M_PCIN, "jr_T3");
    fetch(32'hC0000000, "mfhi");
    cyc(RB | M_HIOUT | M_GRA | M_RIN, "mfhi_T3");
    fetch(32'hD0000000, "nop");
    cyc(RB, "nop_T3");
    fetch(32'hF8000000, "undef");
    cyc(RB, "undef_T3");

    // clr in st T6: reset before Write, then a clean fetch
    fetch(32'h10000000, "stclr");
    cyc(RB | M_GRB | M_BAOUT | M_YIN, "stclr_T3");
    cyc(RB | M_COUT | M_ZHIN | M_ZLIN, "stclr_T4");
    cyc(RB | M_ZLOUT | M_MARIN, "stclr_T5");
    clr = 1'b1;
    cyc(RB | M_GRA | M_ROUT | M_MDRIN, "stclr_T6");
    clr = 1'b0;
    cyc(RSTV, "stclr_rst");
    fetch(32'hD0000000, "after_clr");
    cyc(RB, "after_clr_T3");

    // halt instruction
    fetch(32'hD8000000, "halt");
    cyc(RB, "halt_T3");
    for (int i = 0; i < 11; i++) cyc(HLT, "halt_hold");
    clr = 1'b1;
    cyc(HLT, "halt_clr");
    clr = 1'b0;
    cyc(RSTV, "halt_rst");

    // stop sampled in T0
    stop = 1'b1;
    IR = 32'h18918000;
    cyc(RB | M_PCOUT | M_MARIN | M_INCPC, "stop_T0");
    stop = 1'b0;
    for (int i = 0; i < 3; i++) cyc(HLT, "stop_halt");
    clr = 1'b1;
    cyc(HLT, "stop_clr");
    clr = 1'b0;
    cyc(RSTV, "stop_rst");
    cyc(RB | M_PCOUT | M_MARIN | M_INCPC, "stop_recover_T0");

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
